// File: rtl/fht_adc_loader.sv
// Captures one N-point frame of ADC samples into the FHT input RAM (bank index
// bit-reversed), pulses the FHT start, then waits for FHT ready before re-arming or idling.
module fht_adc_loader #(
    parameter int N     = 1024,
    parameter int A_BIT = 8,
    parameter int ADC_W = 15
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iARM,
    input  logic             iCONT,
    input  logic             iABORT,
    input  logic             iVALID,
    input  logic [ADC_W-1:0] iSAMPLE,
    input  logic             iRDY,
    input  logic             iCLR_OVR,
    output logic [ADC_W-1:0] oDATA,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [3:0]       oWE,
    output logic             oSTART,
    output logic             oBUSY,
    output logic             oFRAME_DONE,
    output logic             oOVR
);

    localparam int CNT_W = A_BIT + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GAP  = 3'd2,
        S_STRT = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               blank_q, blank_d;
    logic [ADC_W-1:0]   data_q, data_d;
    logic [A_BIT-1:0]   addr_q, addr_d;
    logic [3:0]         we_q, we_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;

    logic               accept;
    logic               drop;
    logic               rdy_seen;
    logic [1:0]         bank_sel;
    logic [3:0]         we_dec;

    assign accept   = (state_q == S_LOAD) && iVALID && !iABORT;
    assign drop     = iVALID && ((state_q == S_GAP) || (state_q == S_STRT) || (state_q == S_WAIT));
    // The first WAIT cycle is blanked: FHT ready may still be high from the previous frame.
    assign rdy_seen = (state_q == S_WAIT) && !blank_q && iRDY && !iABORT;

    // Quarter index with its two bits swapped gives bank order 0, 2, 1, 3.
    assign bank_sel = {cnt_q[A_BIT], cnt_q[A_BIT+1]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_we
            assign we_dec[gi] = accept && (bank_sel == 2'(gi));
        end
    endgenerate

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            blank_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blank_d = (state_q == S_STRT);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (iARM) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (iABORT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (iVALID) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (iABORT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_STRT;
                end
            end
            S_STRT: begin
                if (iABORT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (iABORT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (rdy_seen) begin
                    cnt_d   = '0;
                    state_d = iCONT ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = we_dec;
        // Registered from STRT, so an abort seen in STRT still lets the pulse complete.
        start_d = (state_q == S_STRT);
        done_d  = rdy_seen;
        busy_d  = (state_d != S_IDLE);
        ovr_d   = ovr_q;
        if (accept) begin
            data_d = iSAMPLE;
            addr_d = cnt_q[A_BIT-1:0];
        end
        if (iCLR_OVR) ovr_d = 1'b0;
        if (drop)     ovr_d = 1'b1;
    end

    assign oDATA       = data_q;
    assign oADDR_WR    = addr_q;
    assign oWE         = we_q;
    assign oSTART      = start_q;
    assign oBUSY       = busy_q;
    assign oFRAME_DONE = done_q;
    assign oOVR        = ovr_q;

endmodule

// File: tb/tb_fht_adc_loader.sv
// Directed bench for fht_adc_loader at N=16: bank ordering, start/done timing,
// continuous mode, overrun flag, abort and asynchronous reset.
module tb_fht_adc_loader;

    localparam int N     = 16;
    localparam int A_BIT = 2;
    localparam int ADC_W = 15;

    logic             iCLK = 1'b0;
    logic             iRESET = 1'b0;
    logic             iARM = 1'b0;
    logic             iCONT = 1'b0;
    logic             iABORT = 1'b0;
    logic             iVALID = 1'b0;
    logic [ADC_W-1:0] iSAMPLE = '0;
    logic             iRDY = 1'b0;
    logic             iCLR_OVR = 1'b0;
    logic [ADC_W-1:0] oDATA;
    logic [A_BIT-1:0] oADDR_WR;
    logic [3:0]       oWE;
    logic             oSTART;
    logic             oBUSY;
    logic             oFRAME_DONE;
    logic             oOVR;

    int n_pass = 0;
    int n_tot  = 0;
    int n_start = 0;
    int bank_of [4] = '{0, 2, 1, 3};

    fht_adc_loader #(.N(N), .A_BIT(A_BIT), .ADC_W(ADC_W)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iARM(iARM), .iCONT(iCONT), .iABORT(iABORT),
        .iVALID(iVALID), .iSAMPLE(iSAMPLE), .iRDY(iRDY), .iCLR_OVR(iCLR_OVR),
        .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE(oWE), .oSTART(oSTART),
        .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .oOVR(oOVR)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
        if (oSTART === 1'b1) n_start++;
    endtask

    // Accepted sample k of a frame: one-hot WE on the bit-reversed bank, in-bank address, data.
    task automatic chk_write(input int k, input logic [ADC_W-1:0] val);
        logic [3:0] one;
        one = 4'b0001;
        $display("write k=%0d we=%b addr=%0d data=%0h", k, oWE, oADDR_WR, oDATA);
        chk("we", 32'(oWE), 32'(one << bank_of[k / 4]));
        chk("addr", 32'(oADDR_WR), 32'(k % 4));
        chk("data", 32'(oDATA), 32'(val));
    endtask

    initial begin
        logic [ADC_W-1:0] s;
        // Reset state
        tick();
        tick();
        chk("rst_we", 32'(oWE), 32'd0);
        chk("rst_outs", {26'd0, oSTART, oBUSY, oFRAME_DONE, oOVR, 2'd0}, 32'd0);
        chk("rst_data", 32'(oDATA), 32'd0);
        #3 iRESET = 1'b1;
        tick();

        // Case 1: back-to-back frame of k=0..15
        iARM = 1'b1;
        tick();
        iARM = 1'b0;
        chk("arm_busy", 32'(oBUSY), 32'd1);
        for (int k = 0; k < N; k++) begin
            iVALID = 1'b1;
            iSAMPLE = ADC_W'(k);
            tick();
            chk_write(k, ADC_W'(k));
        end
        iVALID = 1'b0;
        iRDY = 1'b1;
        tick();
        chk("gap_we", 32'(oWE), 32'd0);
        chk("gap_start", 32'(oSTART), 32'd0);
        tick();
        $display("start=%b two cycles after last write", oSTART);
        chk("start", 32'(oSTART), 32'd1);

        // Case 2: iRDY held high, blanking must delay done by one cycle
        tick();
        chk("blank_start", 32'(oSTART), 32'd0);
        chk("blank_done", 32'(oFRAME_DONE), 32'd0);
        tick();
        $display("frame_done=%b busy=%b", oFRAME_DONE, oBUSY);
        chk("done", 32'(oFRAME_DONE), 32'd1);
        chk("done_idle", 32'(oBUSY), 32'd0);
        iRDY = 1'b0;
        tick();
        chk("done_pulse", 32'(oFRAME_DONE), 32'd0);

        // Case 3: continuous mode, gapped valid, negative samples
        n_start = 0;
        iCONT = 1'b1;
        iARM = 1'b1;
        tick();
        iARM = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) begin
                s = ADC_W'(-5 - k);
                iVALID = 1'b1;
                iSAMPLE = s;
                tick();
                chk_write(k, s);
                iVALID = 1'b0;
                iSAMPLE = '0;
                tick();
                chk("gapped_we", 32'(oWE), 32'd0);
                chk("gapped_hold", 32'(oDATA), 32'(s));
                tick();
            end
            if (f == 0) iRDY = 1'b1;
            else iCONT = 1'b0;
            iRDY = 1'b1;
            tick();
            tick();
            $display("frame %0d done=%b busy=%b", f, oFRAME_DONE, oBUSY);
            chk("cont_done", 32'(oFRAME_DONE), 32'd1);
            chk("cont_busy", 32'(oBUSY), (f == 0) ? 32'd1 : 32'd0);
            iRDY = 1'b0;
        end
        chk("cont_starts", 32'(n_start), 32'd2);

        // Case 4: valid held through GAP/STRT/WAIT
        iARM = 1'b1;
        tick();
        iARM = 1'b0;
        iVALID = 1'b1;
        for (int k = 0; k < N; k++) begin
            iSAMPLE = ADC_W'(k + 100);
            tick();
        end
        chk("ovr_pre", 32'(oOVR), 32'd0);
        tick();
        chk("ovr_gap_we", 32'(oWE), 32'd0);
        chk("ovr_set", 32'(oOVR), 32'd1);
        tick();
        chk("ovr_strt_we", 32'(oWE), 32'd0);
        tick();
        chk("ovr_wait_we", 32'(oWE), 32'd0);
        iVALID = 1'b0;
        iCLR_OVR = 1'b1;
        tick();
        $display("ovr after clear=%b", oOVR);
        chk("ovr_clr", 32'(oOVR), 32'd0);
        iVALID = 1'b1;
        tick();
        chk("ovr_set_wins", 32'(oOVR), 32'd1);
        iVALID = 1'b0;
        tick();
        iCLR_OVR = 1'b0;
        chk("ovr_clr2", 32'(oOVR), 32'd0);
        iRDY = 1'b1;
        tick();
        chk("ovr_done", 32'(oFRAME_DONE), 32'd1);
        iRDY = 1'b0;
        iVALID = 1'b1;
        tick();
        tick();
        chk("idle_valid_ovr", 32'(oOVR), 32'd0);
        chk("idle_valid_we", 32'(oWE), 32'd0);
        iVALID = 1'b0;

        // Case 5: abort after 7 samples
        n_start = 0;
        iARM = 1'b1;
        tick();
        iARM = 1'b0;
        for (int k = 0; k < 7; k++) begin
            iVALID = 1'b1;
            iSAMPLE = ADC_W'(k + 50);
            tick();
        end
        iABORT = 1'b1;
        iSAMPLE = ADC_W'(77);
        tick();
        iABORT = 1'b0;
        iVALID = 1'b0;
        $display("abort we=%b busy=%b", oWE, oBUSY);
        chk("abort_we", 32'(oWE), 32'd0);
        chk("abort_busy", 32'(oBUSY), 32'd0);
        chk("abort_data", 32'(oDATA), 32'd56);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_nostart", 32'(n_start), 32'd0);
        iARM = 1'b1;
        tick();
        iARM = 1'b0;
        iVALID = 1'b1;
        iSAMPLE = ADC_W'(200);
        tick();
        chk_write(0, ADC_W'(200));

        // Case 6: asynchronous reset mid-LOAD
        iSAMPLE = ADC_W'(201);
        tick();
        iSAMPLE = ADC_W'(202);
        tick();
        chk_write(2, ADC_W'(202));
        #2 iRESET = 1'b0;
        #1;
        $display("async reset we=%b busy=%b data=%0h", oWE, oBUSY, oDATA);
        chk("arst_we", 32'(oWE), 32'd0);
        chk("arst_busy", 32'(oBUSY), 32'd0);
        chk("arst_data", 32'(oDATA), 32'd0);
        chk("arst_addr", 32'(oADDR_WR), 32'd0);
        tick();
        #2 iRESET = 1'b1;
        n_start = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("arst_idle", 32'(oBUSY), 32'd0);
        chk("arst_we_idle", 32'(oWE), 32'd0);
        chk("arst_nostart", 32'(n_start), 32'd0);
        iVALID = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
